rf_sb: RTL

Parametrised register file with a built-in scoreboard, for pipelined miniRV cores with a long-latency load/multiply writeback path.
- Two read ports, two write ports: port A for the ALU/early writeback, port B for long-latency writeback.
- Write-to-read bypass on both write ports.
- Per-register pending bits drive the issue-stage hazard signal, so the decode stage can stall instead of tracking hazards itself.
- Hardwired zero register; indices at or above NREGS read zero (RV32E-style).

---
 rtl/rf_sb.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rf_sb.sv
// rf_sb: two-read / two-write register file with a per-register scoreboard.
// Port A carries early (ALU) writeback, port B carries long-latency writeback
// and retires the pending bit set when the long instruction was issued.
// Register 0 and any index at or above NREGS read as zero and ignore writes.
module rf_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 16,
    parameter int AW    = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AW-1:0]               rs1,
    input  logic [AW-1:0]               rs2,
    output logic [XLEN-1:0]             rdata1,
    output logic [XLEN-1:0]             rdata2,
    input  logic                        wa_en,
    input  logic [AW-1:0]               wa_rd,
    input  logic [XLEN-1:0]             wa_data,
    input  logic                        wb_en,
    input  logic [AW-1:0]               wb_rd,
    input  logic [XLEN-1:0]             wb_data,
    input  logic                        iss_valid,
    input  logic [AW-1:0]               iss_rd,
    input  logic                        iss_long,
    output logic                        hazard,
    output logic [NREGS-1:0]            pending,
    output logic                        err,
    output logic [NREGS-1:0][XLEN-1:0]  regs_out
);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           pending_q, pending_d;
    logic                       err_q, err_d;

    // One-hot decodes of each index; bit 0 and out-of-range indices never match.
    logic [NREGS-1:0] wa_hit, wb_hit, iss_hit, eff_pend, set_vec;
    logic             wa_drop;
    logic             iss_accept;

    // Pending bit of a register as seen this cycle; invalid indices give 0.
    function automatic logic pend_at(input logic [AW-1:0] idx, input logic [NREGS-1:0] vec);
        logic v;
        v = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (idx == AW'(r)) v = vec[r];
        end
        return v;
    endfunction

    // Read data for one port: zero for invalid index, then A bypass, B bypass, storage.
    function automatic logic [XLEN-1:0] read_port(
        input logic [AW-1:0]              idx,
        input logic [NREGS-1:0][XLEN-1:0] regs
    );
        logic [XLEN-1:0] v;
        v = '0;
        for (int r = 1; r < NREGS; r++) begin
            if (idx == AW'(r)) begin
                if (wa_en && wa_rd == idx)      v = wa_data;
                else if (wb_en && wb_rd == idx) v = wb_data;
                else                            v = regs[r];
            end
        end
        return v;
    endfunction

    // Decode write and issue destinations into per-register hit vectors.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wa_hit  = '0;
        wb_hit  = '0;
        iss_hit = '0;
        for (int r = 1; r < NREGS; r++) begin
            wa_hit[r]  = wa_en && (wa_rd == AW'(r));
            wb_hit[r]  = wb_en && (wb_rd == AW'(r));
            iss_hit[r] = iss_rd == AW'(r);
        end
    end

    // Scoreboard view this cycle, hazard, and read ports.
    always_comb begin
        eff_pend   = pending_q & ~wb_hit;
        hazard     = iss_valid && (pend_at(rs1, eff_pend) || pend_at(rs2, eff_pend) ||
                                   pend_at(iss_rd, eff_pend));
        iss_accept = iss_valid && !hazard;
        set_vec    = (iss_accept && iss_long) ? iss_hit : '0;
        // A port-A write into a still-pending register would be overtaken by the
        // long-latency result, so it is dropped and flagged.
        wa_drop    = |(wa_hit & eff_pend);
        rdata1     = read_port(rs1, regs_q);
        rdata2     = read_port(rs2, regs_q);
    end

    // Next-state for storage, pending bits and the sticky error flag.
    always_comb begin
        regs_d    = regs_q;
        pending_d = eff_pend | set_vec;
        err_d     = err_q | wa_drop;
        for (int r = 1; r < NREGS; r++) begin
            // Port A wins over port B: it belongs to the younger instruction.
            if (wa_hit[r] && !wa_drop) regs_d[r] = wa_data;
            else if (wb_hit[r])        regs_d[r] = wb_data;
        end
        regs_d[0] = '0;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the register array is built from flops rather than a RAM so that reset can clear it.
            regs_q    <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            regs_q    <= regs_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign pending  = pending_q;
    assign err      = err_q;
    assign regs_out = regs_q;

endmodule
